// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Contents: loader FSM state encoding, header byte count, bytes per instruction word.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    RUN,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    RELEASE,
    ERR
  } state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_rx_word_asm.sv
// Byte-to-word assembler with inter-byte idle watchdog.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear        restart assembly: byte index and idle counter to 0
//   count_en     watchdog armed (loader is waiting for bytes)
//   shift_en     accept rx_data into the word (big-endian, MSB first)
//   rx_valid     byte strobe, restarts the idle counter
//   rx_data      received byte
//   word         assembled word
//   word_ready   the byte being shifted in completes a word
//   timeout      idle limit reached this cycle with no byte arriving
module imem_rx_word_asm
  import imem_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        count_en,
  input  logic        shift_en,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [31:0] word,
  output logic        word_ready,
  output logic        timeout
);

  localparam int unsigned IdleW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [31:0]      word_q, word_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

  assign word       = word_q;
  assign word_ready = shift_en && (byte_idx_q == 2'(BYTES_PER_WORD - 1));
  assign timeout    = count_en && !rx_valid && (idle_cnt_q == IdleW'(TIMEOUT - 1));

  always_comb begin
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    idle_cnt_d = idle_cnt_q;
    if (clear) begin
      byte_idx_d = '0;
      idle_cnt_d = '0;
    end else begin
      if (shift_en) begin
        word_d     = {word_q[23:0], rx_data};
        byte_idx_d = byte_idx_q + 2'd1;  // wraps 3 -> 0 at the end of a word
      end
      if (count_en) begin
        if (rx_valid) begin
          idle_cnt_d = '0;
        end else if (!timeout) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q     <= '0;
      byte_idx_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory port owner: CPU fetch passthrough or UART program-image loader.
// Image format: 16-bit big-endian word count, then count big-endian 32-bit words, written
// from word 0 upward. The CPU is held in reset during a load and after any failure.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   load_req         start a load (honoured only in RUN or ERR)
//   rx_valid/rx_data received byte strobe and data
//   cpu_pc           CPU fetch address
//   mem_addr/mem_we/mem_wdata  instruction-memory port
//   cpu_hold         CPU reset request
//   busy             loader not in RUN
//   load_done        one-cycle success pulse
//   load_err         sticky failure flag, cleared when the next load is accepted
//   words_loaded     words written by the current/last load
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned TIMEOUT    = 100000,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_req,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic [31:0]           cpu_pc,
  output logic [31:0]           mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [DEPTH_LOG2:0]   words_loaded
);

  localparam int unsigned HoldW    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;
  localparam logic [16:0] MaxWords = 17'(2 ** DEPTH_LOG2);

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [DEPTH_LOG2:0] words_loaded_q, words_loaded_d;
  logic                load_err_q, load_err_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;

  logic        accept;
  logic        count_en;
  logic        shift_en;
  logic [31:0] word;
  logic        word_ready;
  logic        timeout;
  logic [16:0] wl_next;

  assign accept   = ((state_q == RUN) || (state_q == ERR)) && load_req;
  assign count_en = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
  assign shift_en = (state_q == DATA) && rx_valid;
  assign wl_next  = 17'(words_loaded_q) + 17'd1;

  imem_rx_word_asm #(
    .TIMEOUT (TIMEOUT)
  ) u_word_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .count_en   (count_en),
    .shift_en   (shift_en),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .word       (word),
    .word_ready (word_ready),
    .timeout    (timeout)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    words_loaded_d = words_loaded_q;
    load_err_d     = load_err_q;
    hold_cnt_d     = '0;
    unique case (state_q)
      RUN: begin
        if (load_req) state_d = HDR_HI;
      end
      HDR_HI: begin
        if (rx_valid) begin
          count_d[15:8] = rx_data;
          state_d       = HDR_LO;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      HDR_LO: begin
        if (rx_valid) begin
          count_d[7:0] = rx_data;
          if ((count_d == 16'd0) || ({1'b0, count_d} > MaxWords)) state_d = ERR;
          else                                                     state_d = DATA;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      DATA: begin
        if (word_ready)   state_d = WRITE;
        else if (timeout) state_d = ERR;
      end
      WRITE: begin
        // The write commits even on overrun; the image is still rejected.
        words_loaded_d = words_loaded_q + 1'b1;
        if (rx_valid)                        state_d = ERR;
        else if (wl_next == {1'b0, count_q}) state_d = RELEASE;
        else                                 state_d = DATA;
      end
      RELEASE: begin
        if (hold_cnt_q == HoldW'(RESET_HOLD)) state_d = RUN;
        else                                  hold_cnt_d = hold_cnt_q + 1'b1;
      end
      ERR: begin
        if (load_req) state_d = HDR_HI;
      end
      default: state_d = RUN;
    endcase
    if (accept) begin
      words_loaded_d = '0;
      load_err_d     = 1'b0;
    end
    if ((state_d == ERR) && (state_q != ERR)) load_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      count_q        <= '0;
      words_loaded_q <= '0;
      load_err_q     <= 1'b0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      words_loaded_q <= words_loaded_d;
      load_err_q     <= load_err_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  always_comb begin
    mem_addr  = cpu_pc;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state_q == WRITE) begin
      mem_we    = 1'b1;
      mem_addr  = 32'({words_loaded_q, 2'b00});
      mem_wdata = word;
    end
  end

  assign load_done    = (state_q == RELEASE) && (hold_cnt_q == HoldW'(RESET_HOLD));
  // The release cycle drops hold so the CPU restarts at PC=0 alongside load_done.
  assign cpu_hold     = (state_q != RUN) && !load_done;
  assign busy         = (state_q != RUN);
  assign load_err     = load_err_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboarded bench for imem_boot_loader: expected writes and completion word counts are
// queued by the stimulus; a negedge monitor pops and compares them as the DUT presents them.
module tb_imem_boot_loader;

  localparam int unsigned DL = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] cpu_pc;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic [DL:0] words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];

  imem_boot_loader #(
    .DEPTH_LOG2 (DL),
    .TIMEOUT    (16),
    .RESET_HOLD (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_req     (load_req),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .cpu_pc       (cpu_pc),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every write and every completion pulse must match the queued expectation.
  always @(negedge clk) begin
    wr_t e;
    int  d;
    if (mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        e = wr_q.pop_front();
        chk("write_addr", mem_addr, e.addr);
        chk("write_data", mem_wdata, e.data);
      end
    end
    if (load_done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got load_done=1, required 0");
      end else begin
        d = done_q.pop_front();
        chk("done_words", 32'(words_loaded), 32'(d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Four bytes MSB first, then one quiet cycle for the WRITE state.
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    tick();
  endtask

  task automatic wait_run(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cpu_pc   = 32'h8;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state / RUN passthrough
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 32'h8);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    cpu_pc = 32'h0000_0124;
    #1;
    chk("run_addr_comb", mem_addr, 32'h0000_0124);

    // Three-word image
    wr_q.push_back('{addr: 32'h0, data: 32'h2004_0003});
    wr_q.push_back('{addr: 32'h4, data: 32'h0c00_0003});
    wr_q.push_back('{addr: 32'h8, data: 32'h1000_ffff});
    done_q.push_back(3);
    start_load();
    @(negedge clk);
    chk("load_hold", 32'(cpu_hold), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_addr_pc", mem_addr, 32'h0000_0124);
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(32'h2004_0003);
    send_word(32'h0c00_0003);
    send_word(32'h1000_ffff);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("release_hold", 32'(cpu_hold), 32'd1);
      chk("release_no_done", 32'(load_done), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("done_pulse", 32'(load_done), 32'd1);
    chk("done_hold_low", 32'(cpu_hold), 32'd0);
    tick();
    @(negedge clk);
    chk("after_done_busy", 32'(busy), 32'd0);
    chk("after_done_words", 32'(words_loaded), 32'd3);
    chk("after_done_pulse", 32'(load_done), 32'd0);

    // Bad headers, then recovery
    start_load();
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    chk("zero_cnt_err", 32'(load_err), 32'd1);
    chk("zero_cnt_hold", 32'(cpu_hold), 32'd1);
    start_load();
    @(negedge clk);
    chk("err_cleared", 32'(load_err), 32'd0);
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    chk("big_cnt_err", 32'(load_err), 32'd1);
    wr_q.push_back('{addr: 32'h0, data: 32'hdead_beef});
    done_q.push_back(1);
    start_load();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hdead_beef);
    wait_run("recover_run", 20);
    chk("recover_err", 32'(load_err), 32'd0);
    chk("recover_words", 32'(words_loaded), 32'd1);

    // Timeout: 16 cycles after the last byte
    start_load();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'haa);
    send_byte(8'hbb);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) chk("timeout_early", 32'(load_err), 32'd0);
      if (k == 16) chk("timeout_err", 32'(load_err), 32'd1);
    end
    chk("timeout_words", 32'(words_loaded), 32'd0);

    // Overrun in WRITE; load_req mid-DATA ignored
    wr_q.push_back('{addr: 32'h0, data: 32'h1122_3344});
    start_load();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);  // lands in the WRITE cycle
    @(negedge clk);
    chk("overrun_err", 32'(load_err), 32'd1);
    chk("overrun_words", 32'(words_loaded), 32'd1);
    chk("overrun_hold", 32'(cpu_hold), 32'd1);
    send_word(32'h0102_0304);  // ignored in ERR

    // Count of exactly 2**DEPTH_LOG2 accepted; reset aborts mid-word
    wr_q.push_back('{addr: 32'h0, data: 32'haabb_ccdd});
    start_load();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'haabb_ccdd);
    @(negedge clk);
    chk("max_cnt_ok", 32'(load_err), 32'd0);
    chk("max_cnt_busy", 32'(busy), 32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hold", 32'(cpu_hold), 32'd0);
    chk("abort_err", 32'(load_err), 32'd0);
    chk("abort_addr", mem_addr, cpu_pc);
    chk("abort_words", 32'(words_loaded), 32'd0);

    repeat (3) tick();
    chk("pending_writes", 32'(wr_q.size()), 32'd0);
    chk("pending_dones", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
